ckt_stim_sched: RTL and testbench

Scheduler that sequences the 2-input / 2-output sequential benchmark core: it buffers 2-bit stimulus symbols, issues one symbol per clock onto core_in0/core_in1, and initialises the core through its reset at run start. It tags each issued cycle and returns the matching core output pair on a valid/ready response channel.
The core has no enable and advances every clock. Cycles with no usable symbol are therefore filled with a bubble symbol, and the responses to those cycles are dropped. Sits between the test/stimulus fabric and the core instance.

---
 rtl/ckt_stim_sched_if.sv | 24 ++
 rtl/ckt_stim_sched.sv | 161 ++++++++++++++++
 tb/tb_ckt_stim_sched.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ckt_stim_sched_if.sv
// Stimulus and response channels between the test fabric (master) and the
// scheduler (slave).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and its data stable until that edge. A sink may
// raise or lower ready on any cycle.
interface ckt_stim_sched_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;

    modport master (
        output sym_in, sym_valid, rsp_ready,
        input  sym_ready, rsp_data, rsp_valid
    );

    modport slave (
        input  sym_in, sym_valid, rsp_ready,
        output sym_ready, rsp_data, rsp_valid
    );
endinterface

// File: rtl/ckt_stim_sched.sv
// Stimulus scheduler for a free-running 2-in/2-out sequential core. When
// BUBBLE_CNT_EN is defined, the bubble_count output and its counter are added.
module ckt_stim_sched #(
    parameter int         DEPTH     = 8,
    parameter int         RSP_DEPTH = 4,
    parameter int         LAT       = 1,
    parameter int         CNT_W     = 16,
    parameter logic [1:0] IDLE_SYM  = 2'b00
) (
    input  logic             clk,
    input  logic             rst,
    ckt_stim_sched_if.slave  bus,
    input  logic             start,
    input  logic             stop,
    output logic             core_rst_n,
    output logic             core_in0,
    output logic             core_in1,
    input  logic             core_O0,
    input  logic             core_O1,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sym_count,
`ifdef BUBBLE_CNT_EN
    output logic [CNT_W-1:0] bubble_count,
`endif
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int AW  = $clog2(DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int CW  = $clog2(RSP_DEPTH + LAT + 2) + 1;

    state_t state, state_n;
    logic   issue, clr_run;

    // Stimulus FIFO
    logic [1:0]  s_mem [DEPTH];
    logic [AW:0] s_wr, s_rd;
    logic        s_full, s_empty, s_push;

    assign s_empty       = (s_wr == s_rd);
    assign s_full        = (s_wr[AW] != s_rd[AW]) && (s_wr[AW-1:0] == s_rd[AW-1:0]);
    assign bus.sym_ready = !s_full && (state != S_INIT);
    assign s_push        = bus.sym_valid && bus.sym_ready;

    always_ff @(posedge clk) begin
        if (s_push) s_mem[s_wr[AW-1:0]] <= bus.sym_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_wr <= '0;
            s_rd <= '0;
        end else begin
            if (s_push) s_wr <= s_wr + (AW+1)'(1);
            if (issue)  s_rd <= s_rd + (AW+1)'(1);
        end
    end

    // tags[0] lines up with core_in; tags[LAT] lines up with the core output
    logic [LAT:0] tags;
    logic         any_tag;
    assign any_tag = |tags;

    // Response FIFO
    logic [1:0]   r_mem [RSP_DEPTH];
    logic [RAW:0] r_wr, r_rd, r_count;
    logic         r_push, r_pop;

    assign r_push        = tags[LAT];
    assign r_pop         = bus.rsp_valid && bus.rsp_ready;
    assign r_count       = r_wr - r_rd;
    assign bus.rsp_valid = (r_wr != r_rd);
    assign bus.rsp_data  = r_mem[r_rd[RAW-1:0]];

    always_ff @(posedge clk) begin
        if (r_push) r_mem[r_wr[RAW-1:0]] <= {core_O1, core_O0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (r_push) r_wr <= r_wr + (RAW+1)'(1);
            if (r_pop)  r_rd <= r_rd + (RAW+1)'(1);
        end
    end

    // Every real tag still in the pipe owns a response slot, so writes never overflow
    logic [CW-1:0] used;
    logic          credit_ok;

    always_comb begin
        used = CW'(r_count);
        for (int i = 0; i <= LAT; i++) used = used + CW'(tags[i]);
    end
    assign credit_ok = used < CW'(RSP_DEPTH);

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        clr_run = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_INIT;
                    clr_run = 1'b1;
                end
            end
            S_INIT:  state_n = S_RUN;
            S_RUN: begin
                if (stop) state_n = S_DRAIN;
                else      issue   = !s_empty && credit_ok;
            end
            S_DRAIN: if (!any_tag) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= S_IDLE;
            core_rst_n           <= 1'b0;
            {core_in1, core_in0} <= IDLE_SYM;
            tags                 <= '0;
            sym_count            <= '0;
        end else begin
            state                <= state_n;
            // Registered from the next state so the core reset line never glitches
            core_rst_n           <= (state_n == S_RUN) || (state_n == S_DRAIN) ||
                                    (state_n == S_DONE);
            {core_in1, core_in0} <= issue ? s_mem[s_rd[AW-1:0]] : IDLE_SYM;
            tags                 <= {tags[LAT-1:0], issue};
            if (clr_run)
                sym_count <= '0;
            else if (issue && (sym_count != '1))
                sym_count <= sym_count + CNT_W'(1);
        end
    end

`ifdef BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            bubble_count <= '0;
        else if (clr_run)
            bubble_count <= '0;
        else if (((state == S_RUN) || (state == S_DRAIN)) && !issue &&
                 (bubble_count != '1))
            bubble_count <= bubble_count + CNT_W'(1);
    end
`endif

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_ckt_stim_sched.sv
// Bench for ckt_stim_sched: the core is modelled as a 2-bit running sum of its
// inputs, so each response equals the prefix sum of the real symbols issued in the run.
module tb_ckt_stim_sched;

    localparam int         DEPTH     = 8;
    localparam int         RSP_DEPTH = 4;
    localparam int         LAT       = 2;
    localparam int         CNT_W     = 16;
    localparam logic [1:0] IDLE_SYM  = 2'b00;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ckt_stim_sched_if bus();
    logic             start, stop;
    logic             core_rst_n, core_in0, core_in1, core_O0, core_O1;
    logic             busy, done;
    logic [CNT_W-1:0] sym_count;
    logic [2:0]       fsm_state;
`ifdef BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_count;
`endif

    ckt_stim_sched #(
        .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH), .LAT(LAT), .CNT_W(CNT_W), .IDLE_SYM(IDLE_SYM)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .start(start), .stop(stop),
        .core_rst_n(core_rst_n), .core_in0(core_in0), .core_in1(core_in1),
        .core_O0(core_O0), .core_O1(core_O1), .busy(busy), .done(done),
        .sym_count(sym_count),
`ifdef BUBBLE_CNT_EN
        .bubble_count(bubble_count),
`endif
        .fsm_state(fsm_state)
    );

    // Core model: running sum, visible LAT clocks after the input is applied
    logic [1:0] dly [LAT];
    always @(posedge clk) begin
        if (!core_rst_n) dly[0] <= 2'b00;
        else             dly[0] <= dly[0] + {core_in1, core_in0};
        for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
    assign core_O0 = dly[LAT-1][0];
    assign core_O1 = dly[LAT-1][1];

    // scoreboard state
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];
    logic [1:0] run_sum;
    int         run_rsp, run_busy, run_rstlow, run_done;
    logic       rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: accepted pushes feed exp_q, each response pops one and is checked
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (bus.sym_valid && bus.sym_ready) exp_q.push_back(bus.sym_in);
            if (!busy && start) begin
                run_sum = 2'b00; run_rsp = 0; run_busy = 0; run_rstlow = 0; run_done = 0;
            end
            if (busy) run_busy++;
            if (busy && !core_rst_n) run_rstlow++;
            if (done) run_done++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    run_sum = run_sum + exp_q.pop_front();
                    check("rsp_data", 32'(bus.rsp_data), 32'(run_sum));
                    run_rsp++;
                end
            end
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [1:0] s);
        logic ok;
        ok = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym_in    = s;
        for (int i = 0; i < 40; i++) begin
            if (bus.sym_ready) begin
                cycle();
                ok = 1'b1;
                break;
            end
            cycle();
        end
        bus.sym_valid = 1'b0;
        check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic run_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        check("done_seen", 32'(ok), 32'd1);
        cycle();
    endtask

    task automatic drain_rsp();
        rand_rdy      = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!bus.rsp_valid) break;
            cycle();
        end
        check("drain_empty", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic end_run();
        drain_rsp();
        check("rsp_count", 32'(run_rsp), 32'(sym_count));
        check("init_low_cycles", 32'(run_rstlow), 32'd1);
        check("done_pulses", 32'(run_done), 32'd1);
`ifdef BUBBLE_CNT_EN
        check("bubble_cnt", 32'(bubble_count), 32'(run_busy - 2 - int'(sym_count)));
`endif
    endtask

    task automatic check_reset_vals();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_core_in", 32'({core_in1, core_in0}), 32'(IDLE_SYM));
        check("rst_sym_count", 32'(sym_count), 32'd0);
        check("rst_sym_ready", 32'(bus.sym_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef BUBBLE_CNT_EN
        check("rst_bubble", 32'(bubble_count), 32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [3];
        int         n, rem, len;
        logic       acc;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        bus.sym_in = 2'b00; bus.sym_valid = 1'b0; bus.rsp_ready = 1'b1;
        #2 rst = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        cycle();

        // Preloaded 01,10,11 appear on core_in on consecutive cycles
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11;
        for (int i = 0; i < 3; i++) push(seq[i]);
        run_start();
        check("init_core_rst_n", 32'(core_rst_n), 32'd0);
        check("init_sym_ready", 32'(bus.sym_ready), 32'd0);
        cycle();
        check("run_core_rst_n", 32'(core_rst_n), 32'd1);
        check("run_first_core_in", 32'({core_in1, core_in0}), 32'(IDLE_SYM));
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("seq_core_in", 32'({core_in1, core_in0}), 32'(seq[i]));
        end
        cycle();
        check("seq_after_core_in", 32'({core_in1, core_in0}), 32'(IDLE_SYM));
        run_stop();
        wait_done();
        end_run();
        check("seq_sym_count", 32'(sym_count), 32'd3);

        // Empty stimulus FIFO: only bubbles, no responses
        run_start();
        repeat (5) begin
            cycle();
            check("empty_core_in", 32'({core_in1, core_in0}), 32'(IDLE_SYM));
            check("empty_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end
        run_stop();
        wait_done();
        end_run();
        check("empty_sym_count", 32'(sym_count), 32'd0);

        // Response backpressure limits real issues to RSP_DEPTH
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(2'($urandom_range(0, 3)));
        run_start();
        repeat (20) cycle();
        check("bp_sym_count", 32'(sym_count), 32'(RSP_DEPTH));
        check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("bp_start_ignored", 32'(sym_count), 32'(RSP_DEPTH));
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (sym_count == CNT_W'(8)) break;
            cycle();
        end
        check("bp_all_issued", 32'(sym_count), 32'd8);
        run_stop();
        wait_done();
        end_run();

        // Stop with two real tags in flight; remainder stays queued
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(2'($urandom_range(0, 3)));
        run_start();
        repeat (3) cycle();
        run_stop();
        check("stop_sym_count", 32'(sym_count), 32'd2);
        wait_done();
        check("drain_rsp_before_done", 32'(run_rsp), 32'd2);
        end_run();
        rem = exp_q.size();
        check("stop_remainder", 32'(rem), 32'd4);
        run_start();
        for (int i = 0; i < 40; i++) begin
            if (int'(sym_count) == rem) break;
            cycle();
        end
        run_stop();
        wait_done();
        end_run();
        check("rem_issued", 32'(sym_count), 32'(rem));

        // Randomized runs with random push traffic and random rsp_ready
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 6);
            if (n > DEPTH - exp_q.size()) n = DEPTH - exp_q.size();
            for (int i = 0; i < n; i++) push(2'($urandom_range(0, 3)));
            rand_rdy = 1'b1;
            run_start();
            len = $urandom_range(3, 25);
            for (int c = 0; c < len; c++) begin
                acc = bus.sym_valid && bus.sym_ready;
                cycle();
                if (!bus.sym_valid || acc) begin
                    bus.sym_valid = 1'($urandom_range(0, 1));
                    bus.sym_in    = 2'($urandom_range(0, 3));
                end
            end
            bus.sym_valid = 1'b0;
            run_stop();
            wait_done();
            end_run();
        end

`ifdef BUBBLE_CNT_EN
        // Two symbols, four empty cycles, stop: 4 + stop bubble + 1 drain bubble
        while (exp_q.size() != 0) begin
            run_start();
            repeat (20) cycle();
            run_stop();
            wait_done();
            end_run();
        end
        push(2'b01);
        push(2'b11);
        run_start();
        repeat (7) cycle();
        run_stop();
        wait_done();
        end_run();
        check("bubble_directed", 32'(bubble_count), 32'd6);
`endif

        // Asynchronous reset in the middle of a run
        bus.rsp_ready = 1'b0;
        n = DEPTH - exp_q.size();
        if (n > 5) n = 5;
        for (int i = 0; i < n; i++) push(2'($urandom_range(0, 3)));
        run_start();
        repeat (6) cycle();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_reset_vals();
        cycle();
        cycle();
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        cycle();
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Recovery run after reset
        push(2'b10);
        push(2'b11);
        run_start();
        repeat (6) cycle();
        run_stop();
        wait_done();
        end_run();
        check("recover_sym_count", 32'(sym_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
